l1_dcache_responder: RTL

Direct-mapped, write-back L1 cache that answers the CPU datapath's 16-bit memory interface (`mem_*`) and refills from 128-bit physical memory (`pmem_*`). It sits between the pipelined datapath's MEM stage (the initiator) and the physical-memory model or arbiter.
- Hits complete in the request cycle.
- Misses stall the initiator by withholding `mem_resp` while the block runs a line write-back and/or fill.

---
 rtl/l1_dcache_responder.sv | 98 +++++++++
 1 files changed

// File: rtl/l1_dcache_responder.sv
// l1_dcache_responder: direct-mapped write-back L1 data cache, 16-bit CPU side, 128-bit line refill side
// Ports: clk/rst (async active-high); mem_* CPU request/response, hits answered combinationally;
// pmem_* line fill (pmem_read) and victim write-back (pmem_write), completed by pmem_resp.
module l1_dcache_responder #(
  parameter int NUM_SETS   = 8,
  parameter int LINE_BYTES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_wdata,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);
  localparam int IW = $clog2(NUM_SETS);
  localparam int OW = $clog2(LINE_BYTES);
  localparam int TW = 16 - IW - OW;
  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;
  state_t state;
  logic [TW-1:0] tags [NUM_SETS];
  logic [127:0] lines [NUM_SETS];
  logic [NUM_SETS-1:0] valid, dirty;
  logic [TW-1:0] req_tag, miss_tag;
  logic [IW-1:0] req_idx, miss_idx;
  logic [OW-2:0] req_word;
  logic [6:0] bit_off;
  logic [15:0] byte_mask;
  logic [127:0] wmask;
  logic req, hit, write_hit, unused_ok;
  assign req_tag   = mem_address[15 -: TW];
  assign req_idx   = mem_address[OW +: IW];
  assign req_word  = mem_address[OW-1:1];
  assign unused_ok = mem_address[0];
  assign bit_off   = {req_word, 4'b0};
  assign req       = mem_read | mem_write;
  assign hit       = valid[req_idx] && tags[req_idx] == req_tag;
  assign mem_resp  = !rst && state == IDLE && req && hit;
  assign write_hit = mem_resp && mem_write;
  assign mem_rdata = lines[req_idx][bit_off +: 16];
  assign byte_mask = {{8{mem_byte_enable[1]}}, {8{mem_byte_enable[0]}}};
  assign wmask     = {112'b0, byte_mask} << bit_off;
  assign pmem_write   = state == WRITEBACK;
  assign pmem_read    = state == FILL;
  // Miss address is latched so the pmem side stays stable even if the CPU withdraws the request.
  assign pmem_address = pmem_write ? {tags[miss_idx], miss_idx, {OW{1'b0}}} :
                        pmem_read  ? {miss_tag, miss_idx, {OW{1'b0}}} : 16'h0;
  assign pmem_wdata   = lines[miss_idx];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      valid    <= '0;
      dirty    <= '0;
      miss_tag <= '0;
      miss_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_hit) dirty[req_idx] <= 1'b1;
          else if (req && !hit) begin
            miss_tag <= req_tag;
            miss_idx <= req_idx;
            state    <= dirty[req_idx] ? WRITEBACK : FILL;
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            dirty[miss_idx] <= 1'b0;
            state           <= FILL;
          end
        end
        FILL: begin
          if (pmem_resp) begin
            valid[miss_idx] <= 1'b1;
            dirty[miss_idx] <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (write_hit) lines[req_idx] <= (lines[req_idx] & ~wmask) | ({8{mem_wdata}} & wmask);
    if (pmem_read && pmem_resp) begin
      lines[miss_idx] <= pmem_rdata;
      tags[miss_idx]  <= miss_tag;
    end
  end
endmodule
